// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and constants for the LIF score accumulator bank
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_SCORE_W = 4;
    localparam int DEF_VMEM_W  = 16;

    // All-ones value of a w-bit sum, used as the saturation ceiling.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/lif_score_accum_bank_if.sv
// rtl/lif_score_accum_bank_if.sv - score stream and frozen-sum handshake bundle
interface lif_score_accum_bank_if
    import lif_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int VMEM_W  = DEF_VMEM_W
);
    logic                        scan_start_en;
    logic                        scan_end_en;
    logic [NUM_CH-1:0]           score_valid;
    logic [NUM_CH*SCORE_W-1:0]   score_in;
    logic [NUM_CH*VMEM_W-1:0]    sum_out;
    logic                        sum_valid;
    logic                        sum_ready;
    logic [NUM_CH-1:0]           ovf_flag;
    logic                        busy;
    logic                        start_drop;

    modport master (
        output scan_start_en, scan_end_en, score_valid, score_in, sum_ready,
        input  sum_out, sum_valid, ovf_flag, busy, start_drop
    );

    modport slave (
        input  scan_start_en, scan_end_en, score_valid, score_in, sum_ready,
        output sum_out, sum_valid, ovf_flag, busy, start_drop
    );
endinterface

// File: rtl/lif_sat_adder.sv
// rtl/lif_sat_adder.sv - one-channel widened adder with optional saturation
module lif_sat_adder
    import lif_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int VMEM_W  = DEF_VMEM_W
) (
    input  logic [VMEM_W-1:0]  sum,
    input  logic [SCORE_W-1:0] score,
    input  logic               sat_en,
    output logic [VMEM_W-1:0]  next_sum,
    output logic               carry
);
    localparam logic [VMEM_W-1:0] SAT_VAL = VMEM_W'(sat_max(VMEM_W));

    logic [VMEM_W:0] wide;

    assign wide     = {1'b0, sum} + {{(VMEM_W + 1 - SCORE_W){1'b0}}, score};
    assign carry    = wide[VMEM_W];
    assign next_sum = (sat_en && carry) ? SAT_VAL : wide[VMEM_W-1:0];
endmodule

// File: rtl/lif_score_accum_bank.sv
// rtl/lif_score_accum_bank.sv - multi-channel scan-window score accumulator
module lif_score_accum_bank
    import lif_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int VMEM_W    = DEF_VMEM_W,
    parameter int SAT_EN    = 1,
    parameter int GAP_CLEAR = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    lif_score_accum_bank_if.slave  bus
);
    state_t state, state_nxt;
    logic   clear_all;
    logic   accum_en;
    logic   drop_nxt;
    logic   start_drop_q;

    logic [NUM_CH*VMEM_W-1:0] sum_flat;
    logic [NUM_CH-1:0]        ovf_flat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            start_drop_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            start_drop_q <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clear_all = 1'b0;
        accum_en  = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.scan_start_en) begin
                    clear_all = 1'b1;
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // A restart outranks a close arriving in the same cycle.
                if (bus.scan_start_en) begin
                    clear_all = 1'b1;
                end else begin
                    accum_en = 1'b1;
                    if (bus.scan_end_en) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.sum_ready) begin
                    if (bus.scan_start_en) begin
                        clear_all = 1'b1;
                        state_nxt = ST_ACCUM;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (bus.scan_start_en) begin
                    drop_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [VMEM_W-1:0] sum_q;
        logic [VMEM_W-1:0] sum_add;
        logic              carry;
        logic              ovf_q;

        lif_sat_adder #(.SCORE_W(SCORE_W), .VMEM_W(VMEM_W)) u_add (
            .sum      (sum_q),
            .score    (bus.score_in[c*SCORE_W +: SCORE_W]),
            .sat_en   (SAT_EN != 0),
            .next_sum (sum_add),
            .carry    (carry)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                ovf_q <= 1'b0;
            end else if (clear_all) begin
                sum_q <= '0;
                ovf_q <= 1'b0;
            end else if (accum_en) begin
                if (bus.score_valid[c]) begin
                    sum_q <= sum_add;
                    if (carry) ovf_q <= 1'b1;
                end else if (GAP_CLEAR != 0) begin
                    sum_q <= '0;
                end
            end
        end

        assign sum_flat[c*VMEM_W +: VMEM_W] = sum_q;
        assign ovf_flat[c]                  = ovf_q;
    end

    assign bus.sum_out    = sum_flat;
    assign bus.ovf_flag   = ovf_flat;
    assign bus.sum_valid  = (state == ST_DONE);
    assign bus.busy       = (state == ST_ACCUM);
    assign bus.start_drop = start_drop_q;
endmodule
